// File: rtl/mdr_load_unit.sv
// mdr_load_unit: memory-read stage of the micro-datapath.
// Takes a load command, does a single REQ/ACK read from data memory, extracts
// the byte/halfword/word lane, extends it and holds it in the memory data
// register that feeds the C-bus multiplexer. All outputs are registered.
module mdr_load_unit #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_InHigh,
  input  logic                  IN_LOAD_START,
  input  logic [ADDR_WIDTH-1:0] IN_ADDRESS,
  input  logic [1:0]            IN_SIZE,
  input  logic                  IN_SIGNED,
  output logic                  MEM_REQ,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic                  MEM_ACK,
  input  logic [BUS_WIDTH-1:0]  MEM_RDATA,
  output logic [BUS_WIDTH-1:0]  BUS_OUT_MEMORY,
  output logic                  OUT_C_SELECT,
  output logic                  OUT_BUSY,
  output logic                  OUT_DONE,
  output logic                  OUT_ERROR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Wait counter compares against this value in the last permitted REQ cycle.
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t               r_state;
  logic [7:0]           r_wait;
  logic [1:0]           r_lane;
  logic [1:0]           r_size;
  logic                 r_signed;

  logic                 w_illegal;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [BUS_WIDTH-1:0] w_ext;

  // Command legality: reserved size or a misaligned halfword/word access.
  always_comb begin
    w_illegal = 1'b0;
    case (IN_SIZE)
      SZ_BYTE: w_illegal = 1'b0;
      SZ_HALF: w_illegal = IN_ADDRESS[0];
      SZ_WORD: w_illegal = (IN_ADDRESS[1:0] != 2'b00);
      default: w_illegal = 1'b1;
    endcase
  end

  // Little-endian lane selection and sign/zero extension of the read word.
  always_comb begin
    w_byte = MEM_RDATA[{r_lane, 3'b000} +: 8];
    w_half = MEM_RDATA[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      SZ_BYTE: w_ext = {{(BUS_WIDTH-8){r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_ext = {{(BUS_WIDTH-16){r_signed & w_half[15]}}, w_half};
      default: w_ext = MEM_RDATA;
    endcase
  end

  // Control FSM with registered outputs; done/error/select are single-cycle pulses.
  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      r_state        <= S_IDLE;
      r_wait         <= '0;
      r_lane         <= '0;
      r_size         <= '0;
      r_signed       <= 1'b0;
      MEM_REQ        <= 1'b0;
      MEM_ADDR       <= '0;
      BUS_OUT_MEMORY <= '0;
      OUT_C_SELECT   <= 1'b0;
      OUT_BUSY       <= 1'b0;
      OUT_DONE       <= 1'b0;
      OUT_ERROR      <= 1'b0;
    end else begin
      OUT_DONE     <= 1'b0;
      OUT_ERROR    <= 1'b0;
      OUT_C_SELECT <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (IN_LOAD_START) begin
            r_lane   <= IN_ADDRESS[1:0];
            r_size   <= IN_SIZE;
            r_signed <= IN_SIGNED;
            r_wait   <= '0;
            OUT_BUSY <= 1'b1;
            if (w_illegal) begin
              r_state        <= S_DONE;
              BUS_OUT_MEMORY <= '0;
              OUT_DONE       <= 1'b1;
              OUT_ERROR      <= 1'b1;
            end else begin
              r_state  <= S_REQ;
              MEM_REQ  <= 1'b1;
              MEM_ADDR <= {IN_ADDRESS[ADDR_WIDTH-1:2], 2'b00};
            end
          end
        end
        S_REQ: begin
          // Ack is checked before the timeout so a last-cycle ack still succeeds.
          if (MEM_ACK) begin
            r_state        <= S_DONE;
            MEM_REQ        <= 1'b0;
            BUS_OUT_MEMORY <= w_ext;
            OUT_DONE       <= 1'b1;
            OUT_C_SELECT   <= 1'b1;
          end else if (r_wait == LP_LAST_WAIT) begin
            r_state        <= S_DONE;
            MEM_REQ        <= 1'b0;
            BUS_OUT_MEMORY <= '0;
            OUT_DONE       <= 1'b1;
            OUT_ERROR      <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          OUT_BUSY <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          MEM_REQ  <= 1'b0;
          OUT_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_load_unit.sv
// tb_mdr_load_unit: directed and randomized loads checked against an
// arithmetic reference model of lane extraction, legality and timeout.
module tb_mdr_load_unit;

  localparam int TO = 4;

  logic        CLOCK_50;
  logic        RESET_InHigh;
  logic        IN_LOAD_START;
  logic [31:0] IN_ADDRESS;
  logic [1:0]  IN_SIZE;
  logic        IN_SIGNED;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic [31:0] BUS_OUT_MEMORY;
  logic        OUT_C_SELECT;
  logic        OUT_BUSY;
  logic        OUT_DONE;
  logic        OUT_ERROR;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] exp_bus;

  mdr_load_unit #(
    .BUS_WIDTH (32),
    .ADDR_WIDTH(32),
    .TIMEOUT   (TO)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .RESET_InHigh  (RESET_InHigh),
    .IN_LOAD_START (IN_LOAD_START),
    .IN_ADDRESS    (IN_ADDRESS),
    .IN_SIZE       (IN_SIZE),
    .IN_SIGNED     (IN_SIGNED),
    .MEM_REQ       (MEM_REQ),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_ACK       (MEM_ACK),
    .MEM_RDATA     (MEM_RDATA),
    .BUS_OUT_MEMORY(BUS_OUT_MEMORY),
    .OUT_C_SELECT  (OUT_C_SELECT),
    .OUT_BUSY      (OUT_BUSY),
    .OUT_DONE      (OUT_DONE),
    .OUT_ERROR     (OUT_ERROR)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd3) return 1'b0;
    if (size == 2'd1 && (addr % 2) != 0) return 1'b0;
    if (size == 2'd2 && (addr % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_value(input logic [31:0] addr, input logic [1:0] size,
                                              input logic sgn, input logic [31:0] rdata);
    logic [31:0] v;
    int unsigned off;
    off = addr % 4;
    if (size == 2'd0) begin
      v = (rdata >> (8 * off)) % 256;
      if (sgn && v >= 128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (rdata >> (16 * (off / 2))) % 65536;
      if (sgn && v >= 32768) v = v - 32'd65536;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // One load starting in the current (idle) cycle; ack_at = REQ cycle index of
  // the ack, or negative for none. Ends in the idle cycle after DONE.
  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                         input int ack_at, input logic [31:0] rdata);
    bit acked;
    acked = 1'b0;
    IN_LOAD_START = 1'b1;
    IN_ADDRESS    = addr;
    IN_SIZE       = size;
    IN_SIGNED     = sgn;
    @(posedge CLOCK_50); #1;
    IN_LOAD_START = 1'b0;
    if (!model_legal(addr, size)) begin
      chk("ill_req", {31'd0, MEM_REQ}, 32'd0);
      chk("ill_done", {31'd0, OUT_DONE}, 32'd1);
      chk("ill_err", {31'd0, OUT_ERROR}, 32'd1);
      chk("ill_csel", {31'd0, OUT_C_SELECT}, 32'd0);
      exp_bus = 32'd0;
      chk("ill_bus", BUS_OUT_MEMORY, exp_bus);
    end else begin
      for (int n = 0; n < TO; n++) begin
        chk("req_high", {31'd0, MEM_REQ}, 32'd1);
        chk("req_addr", MEM_ADDR, addr & ~32'd3);
        chk("req_busy", {31'd0, OUT_BUSY}, 32'd1);
        chk("req_nodone", {31'd0, OUT_DONE}, 32'd0);
        // Start strobes and address changes while busy must be ignored.
        IN_LOAD_START = 1'($urandom_range(0, 1));
        IN_ADDRESS    = $urandom;
        IN_SIZE       = 2'($urandom_range(0, 3));
        if (n == ack_at) begin
          MEM_ACK   = 1'b1;
          MEM_RDATA = rdata;
        end else begin
          MEM_ACK   = 1'b0;
          MEM_RDATA = $urandom;
        end
        @(posedge CLOCK_50); #1;
        MEM_ACK       = 1'b0;
        IN_LOAD_START = 1'b0;
        if (n == ack_at) begin
          acked = 1'b1;
          break;
        end
      end
      exp_bus = acked ? model_value(addr, size, sgn, rdata) : 32'd0;
      chk("done_req", {31'd0, MEM_REQ}, 32'd0);
      chk("done_pulse", {31'd0, OUT_DONE}, 32'd1);
      chk("done_err", {31'd0, OUT_ERROR}, {31'd0, !acked});
      chk("done_csel", {31'd0, OUT_C_SELECT}, {31'd0, acked});
      chk("done_bus", BUS_OUT_MEMORY, exp_bus);
    end
    chk("done_busy", {31'd0, OUT_BUSY}, 32'd1);
    // Ack and data during DONE must not disturb the register.
    MEM_ACK   = 1'b1;
    MEM_RDATA = $urandom;
    @(posedge CLOCK_50); #1;
    MEM_ACK = 1'b0;
    chk("idle_busy", {31'd0, OUT_BUSY}, 32'd0);
    chk("idle_done", {31'd0, OUT_DONE}, 32'd0);
    chk("idle_err", {31'd0, OUT_ERROR}, 32'd0);
    chk("idle_bus", BUS_OUT_MEMORY, exp_bus);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    exp_bus       = 32'd0;
    RESET_InHigh  = 1'b1;
    IN_LOAD_START = 1'b0;
    IN_ADDRESS    = 32'd0;
    IN_SIZE       = 2'd0;
    IN_SIGNED     = 1'b0;
    MEM_ACK       = 1'b0;
    MEM_RDATA     = 32'd0;
    #1;
    chk("rst_req", {31'd0, MEM_REQ}, 32'd0);
    chk("rst_addr", MEM_ADDR, 32'd0);
    chk("rst_bus", BUS_OUT_MEMORY, 32'd0);
    chk("rst_csel", {31'd0, OUT_C_SELECT}, 32'd0);
    chk("rst_busy", {31'd0, OUT_BUSY}, 32'd0);
    chk("rst_done", {31'd0, OUT_DONE}, 32'd0);
    chk("rst_err", {31'd0, OUT_ERROR}, 32'd0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    RESET_InHigh = 1'b0;
    @(posedge CLOCK_50); #1;

    // Directed loads.
    do_load(32'h100, 2'd2, 1'b0, 0, 32'hDEADBEEF);
    chk("tp_word", BUS_OUT_MEMORY, 32'hDEADBEEF);
    do_load(32'h203, 2'd0, 1'b1, 2, 32'h80123456);
    chk("tp_sbyte", BUS_OUT_MEMORY, 32'hFFFFFF80);
    do_load(32'h203, 2'd0, 1'b0, 2, 32'h80123456);
    chk("tp_ubyte", BUS_OUT_MEMORY, 32'h00000080);
    do_load(32'h12, 2'd1, 1'b1, 1, 32'h7FFF8001);
    chk("tp_shalf_hi", BUS_OUT_MEMORY, 32'h00007FFF);
    do_load(32'h10, 2'd1, 1'b1, 0, 32'h7FFF8001);
    chk("tp_shalf_lo", BUS_OUT_MEMORY, 32'hFFFF8001);
    do_load(32'h101, 2'd2, 1'b0, 0, 32'h12345678);
    chk("tp_misalign", BUS_OUT_MEMORY, 32'h0);
    do_load(32'h40, 2'd3, 1'b1, 0, 32'h12345678);
    do_load(32'h44, 2'd2, 1'b0, -1, 32'h0);
    chk("tp_timeout", BUS_OUT_MEMORY, 32'h0);
    do_load(32'h48, 2'd2, 1'b0, TO - 1, 32'hCAFEF00D);
    chk("tp_lastack", BUS_OUT_MEMORY, 32'hCAFEF00D);

    // Reset pulsed in the middle of a REQ phase.
    IN_LOAD_START = 1'b1;
    IN_ADDRESS    = 32'h300;
    IN_SIZE       = 2'd2;
    @(posedge CLOCK_50); #1;
    IN_LOAD_START = 1'b0;
    chk("mid_req", {31'd0, MEM_REQ}, 32'd1);
    @(posedge CLOCK_50); #2;
    RESET_InHigh = 1'b1;
    #1;
    exp_bus = 32'd0;
    chk("mid_rst_req", {31'd0, MEM_REQ}, 32'd0);
    chk("mid_rst_busy", {31'd0, OUT_BUSY}, 32'd0);
    chk("mid_rst_bus", BUS_OUT_MEMORY, exp_bus);
    @(posedge CLOCK_50); #1;
    RESET_InHigh = 1'b0;
    MEM_ACK      = 1'b1;
    MEM_RDATA    = 32'h55AA55AA;
    @(posedge CLOCK_50); #1;
    MEM_ACK = 1'b0;
    chk("late_ack_busy", {31'd0, OUT_BUSY}, 32'd0);
    chk("late_ack_done", {31'd0, OUT_DONE}, 32'd0);
    chk("late_ack_bus", BUS_OUT_MEMORY, 32'd0);
    do_load(32'h304, 2'd2, 1'b0, 1, 32'h0BADF00D);
    chk("post_rst", BUS_OUT_MEMORY, 32'h0BADF00D);

    // Randomized loads; ack index TO or more means no ack in time.
    for (int i = 0; i < 40; i++) begin
      do_load($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, TO + 1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
